// File: rtl/mult_accumulator_pkg.sv
// Shared types and default constants for the multiplier / accumulator datapath.
package mult_pkg;

    localparam int unsigned MULT_SIZE  = 6;
    localparam int unsigned MACC_ACC_W = 16;
    localparam int unsigned MACC_TERMS = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } macc_state_e;

endpackage

// File: rtl/mult_accumulator_if.sv
// Product-in / result-out bus of the accumulator.
// The master is the upstream/downstream environment; the slave is the accumulator.
interface mult_accumulator_if import mult_pkg::*; #(
    parameter int unsigned SIZE  = MULT_SIZE,
    parameter int unsigned ACC_W = MACC_ACC_W
);
    logic               prod_valid;
    logic [2*SIZE-1:0]  product;
    logic               in_ready;
    logic               clear;
    logic               acc_valid;
    logic               acc_ready;
    logic [ACC_W-1:0]   acc_out;
    logic               overflow;

    modport master (
        output prod_valid, product, clear, acc_ready,
        input  in_ready, acc_valid, acc_out, overflow
    );

    modport slave (
        input  prod_valid, product, clear, acc_ready,
        output in_ready, acc_valid, acc_out, overflow
    );
endinterface

// File: rtl/mult_accumulator_sat_add.sv
// Accumulator adder: returns the sum and the carry out of the top bit.
// Build option MACC_SAT_EN: when defined, a carry saturates the sum to all-ones;
// otherwise the sum wraps modulo 2^WIDTH.
module macc_sat_add #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);
    logic [WIDTH:0] full;

    // Widened add, carry taken from the extra bit, optional clamp on carry.
    always_comb begin
        full    = {1'b0, a_i} + {1'b0, b_i};
        carry_o = full[WIDTH];
`ifdef MACC_SAT_EN
        sum_o   = full[WIDTH] ? '1 : full[WIDTH-1:0];
`else
        sum_o   = full[WIDTH-1:0];
`endif
    end
endmodule

// File: rtl/mult_accumulator.sv
// Sums TERMS unsigned products into an ACC_W accumulator and presents each
// completed sum on a valid/ready port. Build option MACC_SAT_EN selects
// saturating accumulation (see macc_sat_add).
module mult_accumulator import mult_pkg::*; #(
    parameter int unsigned SIZE  = MULT_SIZE,
    parameter int unsigned ACC_W = MACC_ACC_W,
    parameter int unsigned TERMS = MACC_TERMS
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_accumulator_if.slave  bus
);
    localparam int unsigned CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;

    if (ACC_W < 2*SIZE) begin : g_bad_acc_w
        $error("mult_accumulator: ACC_W must be >= 2*SIZE");
    end
    if (TERMS < 1) begin : g_bad_terms
        $error("mult_accumulator: TERMS must be >= 1");
    end

    macc_state_e       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  out_q, out_d;

    logic [ACC_W-1:0]  sum;
    logic              carry;
    logic              last_term;
    logic              accept;
    logic              result_hs;

    macc_sat_add #(.WIDTH(ACC_W)) u_add (
        .a_i     (acc_q),
        .b_i     (ACC_W'(bus.product)),
        .sum_o   (sum),
        .carry_o (carry)
    );

    // clear takes priority over both handshakes, so it is folded out of accept.
    assign last_term = (cnt_q == CNT_W'(TERMS - 1));
    assign accept    = bus.prod_valid && (state_q == ACCUM) && !bus.clear;
    assign result_hs = (state_q == HOLD) && bus.acc_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave ACCUM on the last accepted term, leave HOLD on handshake or clear.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (accept && last_term)         state_d = HOLD;
            HOLD:    if (bus.clear || bus.acc_ready)  state_d = ACCUM;
            default:                                  state_d = ACCUM;
        endcase
    end

    // FSM-decoded handshake outputs and registered result outputs.
    always_comb begin
        bus.in_ready  = (state_q == ACCUM);
        bus.acc_valid = (state_q == HOLD);
        bus.acc_out   = out_q;
        bus.overflow  = ovf_q;
    end

    // Datapath next-state: accumulate, capture result, flush on clear or handshake.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        out_d = out_q;
        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            acc_d = sum;
            ovf_d = ovf_q | carry;
            if (last_term) begin
                cnt_d = '0;
                out_d = sum;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (result_hs) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: three configurations (defaults, ACC_W=12, TERMS=1)
// checked every cycle against a transaction-level model of the sum.
module tb_mult_accumulator;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Per-instance drive and observe arrays (index 0: default, 1: ACC_W=12, 2: TERMS=1)
    logic        pv  [3];
    logic        clr [3];
    logic        ar  [3];
    logic [11:0] pd  [3];
    logic        ir  [3];
    logic        av  [3];
    logic        ov  [3];
    logic [15:0] ao  [3];

    mult_accumulator_if #(.SIZE(6), .ACC_W(16)) if0 ();
    mult_accumulator_if #(.SIZE(6), .ACC_W(12)) if1 ();
    mult_accumulator_if #(.SIZE(6), .ACC_W(16)) if2 ();

    mult_accumulator #(.SIZE(6), .ACC_W(16), .TERMS(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mult_accumulator #(.SIZE(6), .ACC_W(12), .TERMS(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mult_accumulator #(.SIZE(6), .ACC_W(16), .TERMS(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.prod_valid = pv[0];  assign if0.product = pd[0];
    assign if0.clear      = clr[0]; assign if0.acc_ready = ar[0];
    assign if1.prod_valid = pv[1];  assign if1.product = pd[1];
    assign if1.clear      = clr[1]; assign if1.acc_ready = ar[1];
    assign if2.prod_valid = pv[2];  assign if2.product = pd[2];
    assign if2.clear      = clr[2]; assign if2.acc_ready = ar[2];

    assign ir[0] = if0.in_ready; assign av[0] = if0.acc_valid;
    assign ov[0] = if0.overflow; assign ao[0] = if0.acc_out;
    assign ir[1] = if1.in_ready; assign av[1] = if1.acc_valid;
    assign ov[1] = if1.overflow; assign ao[1] = {4'b0, if1.acc_out};
    assign ir[2] = if2.in_ready; assign av[2] = if2.acc_valid;
    assign ov[2] = if2.overflow; assign ao[2] = if2.acc_out;

    // Model: count of accepted terms, their exact (unbounded) total, hold flag, last result.
    int unsigned     m_n    [3];
    longint unsigned m_tot  [3];
    bit              m_hold [3];
    longint unsigned m_last [3];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic int unsigned width_of(int k);
        return (k == 1) ? 12 : 16;
    endfunction

    function automatic int unsigned terms_of(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic longint unsigned limit_of(int k);
        return longint'(1) << width_of(k);
    endfunction

    // Result of a term set: exact total if it fits, otherwise clamp or wrap.
    function automatic longint unsigned result_of(int k);
        if (m_tot[k] < limit_of(k)) return m_tot[k];
`ifdef MACC_SAT_EN
        return limit_of(k) - 1;
`else
        return m_tot[k] % limit_of(k);
`endif
    endfunction

    task automatic check(string tag, longint unsigned got, longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_n[k] = 0; m_tot[k] = 0; m_hold[k] = 1'b0; m_last[k] = 0;
        end
    endfunction

    // Apply the inputs presented before the coming edge to the model.
    function automatic void model_step(int k);
        if (clr[k]) begin
            m_n[k] = 0; m_tot[k] = 0; m_hold[k] = 1'b0;
        end else if (m_hold[k]) begin
            if (ar[k]) begin
                m_n[k] = 0; m_tot[k] = 0; m_hold[k] = 1'b0;
            end
        end else if (pv[k]) begin
            m_tot[k] += pd[k];
            m_n[k]++;
            if (m_n[k] == terms_of(k)) begin
                m_hold[k] = 1'b1;
                m_last[k] = result_of(k);
            end
        end
    endfunction

    task automatic check_all(int k);
        check($sformatf("d%0d.in_ready", k),  ir[k], !m_hold[k]);
        check($sformatf("d%0d.acc_valid", k), av[k], m_hold[k]);
        check($sformatf("d%0d.overflow", k),  ov[k], m_tot[k] >= limit_of(k));
        check($sformatf("d%0d.acc_out", k),   ao[k], m_last[k]);
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0; clr[k] = 1'b0; ar[k] = 1'b0; pd[k] = '0;
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_all(k);
    endtask

    task automatic feed0(logic [11:0] val);
        pv[0] = 1'b1; pd[0] = val;
        tick();
    endtask

    int unsigned results;

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) check_all(k);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Four 63x63 products back to back, then 5 cycles of backpressure.
        for (int i = 0; i < 4; i++) feed0(12'd3969);
        check("dflt.valid", av[0], 1);
        check("dflt.sum", ao[0], 15876);
        check("dflt.ovf", ov[0], 0);
        for (int i = 0; i < 5; i++) feed0(12'd7);
        check("bp.in_ready", ir[0], 0);
        check("bp.sum_stable", ao[0], 15876);
        pv[0] = 1'b0; ar[0] = 1'b1;
        tick();
        ar[0] = 1'b0;
        check("bp.in_ready_after", ir[0], 1);

        // Clear after two terms, colliding with a third; next result is 1+2+3+4.
        feed0(12'd10);
        feed0(12'd20);
        clr[0] = 1'b1;
        feed0(12'd30);
        clr[0] = 1'b0;
        for (int i = 1; i <= 4; i++) feed0(12'(i));
        check("clr.sum", ao[0], 10);
        pv[0] = 1'b0; ar[0] = 1'b1;
        tick();
        ar[0] = 1'b0;

        // Overflow on the 12-bit accumulator: 4095 + 1 + 0 + 0.
        pv[1] = 1'b1;
        pd[1] = 12'd4095; tick();
        pd[1] = 12'd1;    tick();
        pd[1] = 12'd0;    tick();
        tick();
        pv[1] = 1'b0;
`ifdef MACC_SAT_EN
        check("ovf.sum", ao[1], 4095);
`else
        check("ovf.sum", ao[1], 0);
`endif
        check("ovf.flag", ov[1], 1);
        ar[1] = 1'b1;
        tick();
        ar[1] = 1'b0;

        // Asynchronous reset after three accepted terms.
        for (int i = 0; i < 3; i++) feed0(12'd5);
        pv[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) check_all(k);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) feed0(12'd5);
        check("rst.sum", ao[0], 20);
        pv[0] = 1'b0; ar[0] = 1'b1;
        tick();
        ar[0] = 1'b0;

        // TERMS=1 with continuous ready: one result every two cycles.
        results = 0;
        pv[2] = 1'b1; pd[2] = 12'd100; ar[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (av[2]) results++;
        end
        check("t1.sum", ao[2], 100);
        check("t1.rate", results, 5);
        idle();
        tick();

        // Random traffic on all three instances.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                pv[k]  = ($urandom_range(0, 3) != 0);
                clr[k] = ($urandom_range(0, 24) == 0);
                ar[k]  = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 3))
                    0:       pd[k] = 12'd0;
                    1:       pd[k] = 12'hFFF;
                    default: pd[k] = 12'($urandom);
                endcase
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
